// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_scheduler_pkg
// Description : Shared types and constants for the UART transmit scheduler:
//               scheduler state encoding, UART register map, CON bit indices.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE      = 3'd1,
        WAIT_START = 3'd2,
        WAIT_DONE  = 3'd3,
        CLEAR      = 3'd4
    } sched_state_t;

    localparam logic [31:0] c_txd_addr        = 32'h4000_0018;
    localparam logic [31:0] c_con_addr        = 32'h4000_0020;
    localparam int          c_con_sending_bit = 4;
    localparam int          c_con_done_bit    = 2;

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_byte_fifo
// Description : Single-clock byte FIFO with wrap-around pointers one bit
//               wider than the index, so full and empty are distinguishable.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_aw = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [c_aw:0] r_wr_ptr;
    logic [c_aw:0] r_rd_ptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign level = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[c_aw-1:0]];

    // Pointer update; contents are discarded on reset by clearing both pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Shares the UART transmitter between two byte requesters and
//               the CPU. Requester bytes are queued and sent through register
//               accesses (TXD write, CON polls, TXD read); the CPU always has
//               bus priority and stalls the scheduler for that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter int          TIMEOUT    = 1023,
    parameter logic [31:0] TXD_ADDR   = c_txd_addr,
    parameter logic [31:0] CON_ADDR   = c_con_addr
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req0,
    input  logic                          req1,
    input  logic [7:0]                    data0,
    input  logic [7:0]                    data1,
    output logic                          ack0,
    output logic                          ack1,
    input  logic                          cpu_rd,
    input  logic                          cpu_wr,
    input  logic [31:0]                   cpu_addr,
    input  logic [31:0]                   cpu_wdata,
    output logic [31:0]                   cpu_rdata,
    output logic                          p_rd,
    output logic                          p_wr,
    output logic [31:0]                   p_addr,
    output logic [31:0]                   p_wdata,
    input  logic [31:0]                   p_rdata,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          err
);

    localparam int                c_cw      = $clog2(TIMEOUT + 1);
    localparam logic [c_cw-1:0]   c_timeout = c_cw'(TIMEOUT);

    sched_state_t     r_state;
    logic [c_cw-1:0]  r_cnt;
    logic [7:0]       r_byte;
    logic             r_rr;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_err;

    logic             w_stall;
    logic             w_elig0;
    logic             w_elig1;
    logic             w_sel1;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_din;
    logic [7:0]       w_dout;
    logic             w_full;
    logic             w_empty;
    logic             w_s_rd;
    logic             w_s_wr;
    logic [31:0]      w_s_addr;
    logic [31:0]      w_s_wdata;

    // A requester whose ack is showing still presents the byte just taken,
    // so it is ignored for that one cycle.
    assign w_elig0 = req0 & ~r_ack0;
    assign w_elig1 = req1 & ~r_ack1;
    assign w_sel1  = w_elig1 & (~w_elig0 | r_rr);
    assign w_push  = (w_elig0 | w_elig1) & ~w_full;
    assign w_din   = w_sel1 ? data1 : data0;

    assign w_stall = cpu_rd | cpu_wr;
    assign w_pop   = (r_state == IDLE) & ~w_stall & ~w_empty;

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    // Bus access owned by the current scheduler state
    always_comb begin
        w_s_rd    = 1'b0;
        w_s_wr    = 1'b0;
        w_s_addr  = '0;
        w_s_wdata = '0;
        case (r_state)
            WRITE: begin
                w_s_wr    = 1'b1;
                w_s_addr  = TXD_ADDR;
                w_s_wdata = {24'b0, r_byte};
            end
            WAIT_START, WAIT_DONE: begin
                w_s_rd   = 1'b1;
                w_s_addr = CON_ADDR;
            end
            CLEAR: begin
                w_s_rd   = 1'b1;
                w_s_addr = TXD_ADDR;
            end
            default: ;
        endcase
    end

    // Peripheral bus mux: CPU first, otherwise the scheduler's access
    always_comb begin
        if (w_stall) begin
            p_rd    = cpu_rd;
            p_wr    = cpu_wr;
            p_addr  = cpu_addr;
            p_wdata = cpu_wdata;
        end else begin
            p_rd    = w_s_rd;
            p_wr    = w_s_wr;
            p_addr  = w_s_addr;
            p_wdata = w_s_wdata;
        end
    end

    assign cpu_rdata = p_rdata;
    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign err       = r_err;
    assign busy      = (r_state != IDLE);

    // Requester acknowledge pulses and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_rr   <= 1'b0;
        end else begin
            r_ack0 <= w_push & ~w_sel1;
            r_ack1 <= w_push & w_sel1;
            if (w_push && w_elig0 && w_elig1) r_rr <= ~w_sel1;
        end
    end

    // Transmission sequencer; a stalled cycle holds state and counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_byte  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (!w_stall) begin
                case (r_state)
                    IDLE: begin
                        if (!w_empty) begin
                            r_byte  <= w_dout;
                            r_state <= WRITE;
                        end
                    end
                    WRITE: begin
                        r_cnt   <= '0;
                        r_state <= WAIT_START;
                    end
                    WAIT_START: begin
                        if (p_rdata[c_con_sending_bit]) begin
                            r_cnt   <= '0;
                            r_state <= WAIT_DONE;
                        end else if (r_cnt == c_timeout) begin
                            r_err   <= 1'b1;
                            r_state <= CLEAR;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    WAIT_DONE: begin
                        if (!p_rdata[c_con_sending_bit] && p_rdata[c_con_done_bit]) begin
                            r_state <= CLEAR;
                        end else if (r_cnt == c_timeout) begin
                            r_err   <= 1'b1;
                            r_state <= CLEAR;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    CLEAR: begin
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Bus-mastering controller that shares the UART transmitter between two byte requesters and the CPU.
- Sits between the CPU peripheral-bus signals and the peripheral block. Muxes the CPU and its own accesses onto one rd/wr/addr/wdata bus, with the CPU always taking priority.
- Buffers requester bytes in a small FIFO. Sequences each transmission by register access: write TXD, poll CON until the send starts, poll CON until it completes, then read TXD to clear the done flag.

Parameters:
- FIFO_DEPTH, 4, byte FIFO entries; power of two, at least 2.
- TIMEOUT, 1023, maximum cycles spent in either poll state before abort.
- TXD_ADDR, 32'h40000018, UART transmit-data register.
- CON_ADDR, 32'h40000020, UART control/status register; bit4 = sending, bit2 = done.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- req0, req1  in  1 each  requester byte-valid
- data0, data1  in  8 each  requester bytes
- ack0, ack1  out  1 each  one-cycle accept pulse
- cpu_rd, cpu_wr  in  1 each  CPU bus strobes
- cpu_addr, cpu_wdata  in  32 each  CPU bus address / write data
- cpu_rdata  out  32  read data returned to the CPU
- p_rd, p_wr  out  1 each  peripheral bus strobes
- p_addr, p_wdata  out  32 each  peripheral bus address / write data
- p_rdata  in  32  peripheral read data; combinational, valid in the same cycle
- busy  out  1  state is not IDLE
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Interface: reset is asynchronous and active-low; clock is clk.
- Reset values:
  - ack0/1 = 0, busy = 0, level = 0, err = 0.
  - State = IDLE, round-robin pointer = 0 (requester 0 favoured), FIFO empty, counter = 0.
- Bus mux (combinational):
  - If cpu_rd or cpu_wr is high, p_* = cpu_* and the scheduler is stalled this cycle.
  - Otherwise p_* = the scheduler's access for its current state, or all zeros when it has none.
  - cpu_rdata = p_rdata at all times.
- FIFO push:
  - At most one push per cycle, and only when not full.
  - If exactly one req is high, accept it.
  - If both are high, accept the requester the pointer favours, then flip the pointer to the other requester.
  - ackN is registered, high in the cycle after the push; the requester drops or changes reqN on seeing ack.
  - When full, no ack is issued; req is held by the requester.
  - Push and pop in the same cycle are both allowed, and level is unchanged.
- Scheduler FSM (a stalled cycle holds state and counter):
  - IDLE: if the FIFO is not empty, pop the head into byte_r and go to WRITE.
  - WRITE: drive p_wr, addr TXD_ADDR, wdata {24'b0,byte_r}; go to WAIT_START; counter = 0.
  - WAIT_START: drive p_rd to CON_ADDR.
    - If p_rdata[4] = 1, go to WAIT_DONE with counter = 0.
    - Else if counter = TIMEOUT, go to CLEAR and pulse err.
    - Else counter + 1.
  - WAIT_DONE: drive p_rd to CON_ADDR.
    - If p_rdata[4] = 0 and p_rdata[2] = 1, go to CLEAR.
    - Timeout handling is the same as in WAIT_START.
  - CLEAR: drive p_rd to TXD_ADDR (clears the done flag); go to IDLE.
- Minimum latency from FIFO non-empty to TXD write is 2 cycles with no CPU contention.
- The counter saturates; it never wraps.
- A CPU access that lands in the same cycle as a scheduler access always wins. The scheduler retries the identical access on the next free cycle.
- A reset assertion mid-transmission returns to reset values immediately. FIFO contents are discarded.
- The FIFO uses wrap-around pointers one bit wider than the index; full = MSBs differ and the index bits are equal.

Decomposition:
- Shared package holds the state enum (IDLE, WRITE, WAIT_START, WAIT_DONE, CLEAR), the TXD/CON address constants and the CON bit indices.
- One sub-module: sync_byte_fifo (parameter DEPTH; push/pop/din/dout/full/empty/level).

Test Plan:
- req0 = 1 with data0 = 8'h41, peripheral model raising bit4 after 3 cycles and lowering it (bit2 = 1) 20 cycles later -> ack0 pulses once; bus carries wr 0x40000018 data 0x41, then reads of 0x40000020, then one read of 0x40000018; busy falls; err never pulses.
- req0 and req1 both held, 3 bytes each -> acks alternate 0,1,0,1,0,1 and bytes are transmitted in that order.
- Push 4 bytes with CON stuck at bit4 = 0 -> level reaches 4 and no ack is issued for a 5th request; after TIMEOUT+1 polls err pulses once and the next byte is written.
- CPU asserts cpu_wr to 0x4000000C in the same cycle as the scheduler's WRITE -> p_* shows the CPU access; the TXD write appears the next cycle; the CPU sees no corruption.
- Reset asserted during WAIT_DONE -> all outputs return to reset values asynchronously, level = 0, and no CLEAR read is issued after reset is released.
